// File: rtl/regfile_multiport.sv
// Clocked multi-port register file: one write port and NUM_READ registered read ports,
// with an optional hardwired zero register and selectable write-first/read-first collisions.
module regfile_multiport #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           WriteEn,
    input  logic [ADDR_WIDTH-1:0]          WriteAddr,
    input  logic [DATA_WIDTH-1:0]          WriteData,
    input  logic [NUM_READ-1:0]            ReadEn,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
    output logic [NUM_READ-1:0]            ReadValid,
    output logic                           WriteErr
);

    localparam int unsigned         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam bit                  ZERO_EN = (ZERO_REG != 0);
    localparam bit                  FWD_EN  = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] mem_q     [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_data_d [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_word_c [NUM_READ];
    logic [NUM_READ-1:0]   rd_valid_q;
    logic [NUM_READ-1:0]   rd_valid_d;
    logic                  wr_err_q;
    logic                  wr_err_d;

    logic                  wr_in_range_c;
    logic                  wr_zero_c;
    logic                  wr_ok_c;
    logic [IDX_W-1:0]      wr_idx_c;

    // Write decode: only implemented, non-zero-register addresses commit.
    always_comb begin
        wr_in_range_c = ({1'b0, WriteAddr} < DEPTH_L);
        wr_zero_c     = ZERO_EN && (WriteAddr == '0);
        wr_ok_c       = WriteEn && wr_in_range_c && !wr_zero_c;
        wr_err_d      = WriteEn && !wr_in_range_c;
        wr_idx_c      = IDX_W'(WriteAddr);
    end

    // Per-port read value selection and output packing.
    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr_c;
        logic                  zero_c;
        logic                  oor_c;
        logic                  fwd_c;

        assign addr_c = ReadAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero_c = ZERO_EN && (addr_c == '0);
        assign oor_c  = !({1'b0, addr_c} < DEPTH_L);
        // A dropped write never forwards: zero/out-of-range reads win first.
        assign fwd_c  = FWD_EN && WriteEn && (WriteAddr == addr_c);

        assign rd_word_c[g] = (zero_c || oor_c) ? '0 :
                              fwd_c             ? WriteData :
                                                  mem_q[IDX_W'(addr_c)];

        assign ReadData[g*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[g];
    end

    always_comb begin
        rd_valid_d = ReadEn;
        rd_data_d  = rd_data_q;
        for (int i = 0; i < int'(NUM_READ); i++) begin
            if (ReadEn[i]) begin
                rd_data_d[i] = rd_word_c[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 0; i < int'(NUM_READ); i++) begin
                rd_data_q[i] <= '0;
            end
            rd_valid_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                mem_q[wr_idx_c] <= WriteData;
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign ReadValid = rd_valid_q;
    assign WriteErr  = wr_err_q;

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised, clocked register file. It replaces the purely combinational 32-to-1 register select mux used as the datapath read port.
- One write port and NUM_READ independent registered read ports.
- Optional hardwired zero register.
- Selectable write-first or read-first collision behaviour.
- Sits between the writeback stage and the operand-fetch stage of the datapath.

Parameters:
DATA_WIDTH, 32, bit width of each register and of each data port
ADDR_WIDTH, 5, address width per port
DEPTH, 32, number of implemented registers; must be <= 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = write-first on same-cycle collision; 0 = read-first

Ports:
Clk  input  1  clock; all state updates on the rising edge
Reset_n  input  1  asynchronous, active-low reset
WriteEn  input  1  write strobe
WriteAddr  input  ADDR_WIDTH  write register index
WriteData  input  DATA_WIDTH  write value
ReadEn  input  NUM_READ  per-port read request; bit i = port i
ReadAddr  input  NUM_READ*ADDR_WIDTH  packed read indices; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
ReadData  output  NUM_READ*DATA_WIDTH  packed registered read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
ReadValid  output  NUM_READ  per-port pulse: ReadData[i] was updated this cycle
WriteErr  output  1  registered one-cycle pulse: previous-cycle write targeted an address >= DEPTH

Behaviour:
Reset:
- Reset_n low clears all DEPTH registers, ReadData, ReadValid and WriteErr to 0 immediately, independent of Clk.
- While Reset_n is low, writes and reads are ignored.
- Deassertion is sampled at the first rising edge with Reset_n high. No request is lost or duplicated if reset falls mid-sequence; a pending read simply yields no ReadValid.

Write, at the rising edge with WriteEn=1:
- WriteAddr < DEPTH and not (ZERO_REG=1 and WriteAddr=0): reg[WriteAddr] <= WriteData.
- ZERO_REG=1 and WriteAddr=0: write silently dropped, no error.
- WriteAddr >= DEPTH: write dropped; WriteErr=1 for exactly the next cycle.

Read, per port i, at the rising edge with ReadEn[i]=1:
- ReadData[i] is loaded; ReadValid[i]=1 for that one cycle. Latency is 1 cycle.
- Loaded value, in priority order:
  (a) 0 if ZERO_REG=1 and address=0;
  (b) 0 if address >= DEPTH;
  (c) WriteData if BYPASS=1, WriteEn=1 and WriteAddr equals the read address (write-first forwarding);
  (d) otherwise the pre-edge reg contents. With BYPASS=0 this is always the old value (read-first).
- ReadEn[i]=0: ReadData[i] holds its last value; ReadValid[i]=0.
- Ports are fully independent. Any number of ports may read the same address in the same cycle and all receive identical data.
- A forwarded write of a dropped address (zero register or out of range) is never forwarded: rules (a)/(b) win.

Timing:
- No combinational path from any input to any output; all outputs are registered.
- Back-to-back reads every cycle are supported at full throughput.
- DEPTH < 2**ADDR_WIDTH is legal: unimplemented addresses read 0 and flag on write.

Test Plan:
- Reset then read all 32 addresses on both ports, ReadEn held high -> every ReadData = 0; ReadValid high from the cycle after the first ReadEn.
- Write reg[n] = n for n = 1..31, then read port0 = addr 1,4,5,7,21,14,3 on successive cycles -> ReadData0 = 1,4,5,7,21,14,3 one cycle after each address, port1 in parallel reading 31-n returns 31-n.
- Write addr 0 = 0xDEADBEEF with ZERO_REG=1, then read addr 0 -> 0, WriteErr stays 0. Repeat with ZERO_REG=0 -> reads 0xDEADBEEF.
- Same cycle: write addr 9 = 0x12345678 (old value 9) and read addr 9 on both ports -> BYPASS=1 returns 0x12345678 on both; BYPASS=0 returns 9; next-cycle read returns 0x12345678 in both configurations.
- DEPTH=16, ADDR_WIDTH=5: write addr 20 = 0xFFFF -> WriteErr pulses exactly 1 cycle; read addr 20 -> 0; reg contents unchanged.
- Assert Reset_n low mid-cycle (not on an edge) after loading regs with nonzero data -> ReadData, ReadValid and WriteErr go to 0 without waiting for a Clk edge; after release, reads of previously written regs return 0.
